// File: rtl/axis_reg_array_skid.sv
// Chain of N_STAGES two-entry skid buffers carrying an AXI4-Stream payload; tready is registered per stage.
// Optional AXIS_REG_STALL_CNT_EN adds a saturating 32-bit count of downstream stall cycles.
module axis_reg_array_skid #(
  parameter int N_STAGES  = 2,
  parameter int DATA_BITS = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
`ifdef AXIS_REG_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic                   m_axis_tlast
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int PW        = DATA_BITS + KEEP_BITS + 1;

  typedef logic [PW-1:0] pay_t;

  logic [N_STAGES-1:0] mv_q, mv_d, sv_q, sv_d, rdy_q, rdy_d;
  pay_t                md_q [N_STAGES];
  pay_t                md_d [N_STAGES];
  pay_t                sd_q [N_STAGES];
  pay_t                sd_d [N_STAGES];

  // Index k of the chain is the input side of stage k; index N_STAGES is m_axis.
  logic [N_STAGES:0]   chain_valid, chain_ready;
  pay_t                chain_pay [N_STAGES+1];
  logic [N_STAGES-1:0] in_fire, out_fire;

  assign chain_valid = {mv_q, s_axis_tvalid};
  assign chain_ready = {m_axis_tready, rdy_q};
  assign in_fire     = chain_valid[N_STAGES-1:0] & chain_ready[N_STAGES-1:0];
  assign out_fire    = mv_q & chain_ready[N_STAGES:1];

  always_comb begin
    chain_pay[0] = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    for (int k = 0; k < N_STAGES; k++) begin
      chain_pay[k+1] = md_q[k];
    end
  end

  always_comb begin
    mv_d = mv_q;
    sv_d = sv_q;
    md_d = md_q;
    sd_d = sd_q;
    for (int k = 0; k < N_STAGES; k++) begin
      if (out_fire[k]) begin
        if (sv_q[k]) begin
          md_d[k] = sd_q[k];
          sv_d[k] = 1'b0;
        end else if (in_fire[k]) begin
          md_d[k] = chain_pay[k];
        end else begin
          mv_d[k] = 1'b0;
        end
      end else if (in_fire[k]) begin
        if (mv_q[k]) begin
          sd_d[k] = chain_pay[k];
          sv_d[k] = 1'b1;
        end else begin
          md_d[k] = chain_pay[k];
          mv_d[k] = 1'b1;
        end
      end
    end
    // Ready is a flop of "skid will be empty", so it stays low through reset.
    rdy_d = ~sv_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mv_q  <= '0;
      sv_q  <= '0;
      rdy_q <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        md_q[k] <= '0;
        sd_q[k] <= '0;
      end
    end else begin
      mv_q  <= mv_d;
      sv_q  <= sv_d;
      rdy_q <= rdy_d;
      md_q  <= md_d;
      sd_q  <= sd_d;
    end
  end

  assign s_axis_tready = chain_ready[0];
  assign m_axis_tvalid = chain_valid[N_STAGES];
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = chain_pay[N_STAGES];

`ifdef AXIS_REG_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt_q <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/axis_reg_array_skid.md
Name: axis_reg_array_skid

Overview:
- N-stage AXI4-Stream register slice with full valid/ready backpressure.
- Companion to the static (no-handshake) pipeline register chain. It carries data forward and registers tready backward, so the ready path has no combinational route from m_axis to s_axis.
- Each stage is a 2-entry skid buffer, giving full throughput of 1 beat/cycle.
- Used to close timing on long streaming routes between shell, dynamic region and user logic.

Parameters:
- N_STAGES, 2, number of skid stages; legal range 1..8.
- DATA_BITS, AXI_DATA_BITS, tdata width; tkeep width is DATA_BITS/8.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tready  out  1  upstream ready (registered)
- s_axis_tdata  in  DATA_BITS  upstream data
- s_axis_tkeep  in  DATA_BITS/8  upstream byte enables
- s_axis_tlast  in  1  upstream end of packet
- m_axis_tvalid  out  1  downstream beat valid (registered)
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_BITS  downstream data (registered)
- m_axis_tkeep  out  DATA_BITS/8  downstream byte enables
- m_axis_tlast  out  1  downstream end of packet

Behaviour:
- Reset: one clock (aclk); reset is asynchronous and active-low (aresetn).
  - While aresetn=0, every main/skid valid flag clears immediately, all data regs clear to 0, and s_axis_tready=0 and m_axis_tvalid=0.
  - s_axis_tready rises on the first aclk edge after aresetn deasserts.
  - Reset mid-packet drops all buffered beats; no partial beat is emitted afterwards.
- Stage structure: stage k has a main reg {mv, md} and a skid reg {sv, sd}. Stage k drives out_valid=mv and in_ready=~sv, both registered.
  - Stage 0 input is s_axis. Stage N_STAGES-1 output is m_axis. The payload is {tdata, tkeep, tlast}.
- Per-stage transitions, with in_fire = in_valid & in_ready and out_fire = mv & out_ready:
  - Empty (mv=0, sv=0): in_fire loads main.
  - Main only (mv=1, sv=0):
    - in_fire & out_fire: main takes the new beat.
    - in_fire & ~out_fire: the new beat goes to skid; in_ready drops next cycle.
    - ~in_fire & out_fire: main empties.
  - Full (mv=1, sv=1): in_ready=0. On out_fire, skid moves to main and sv clears.
- Latency: N_STAGES cycles from s_axis fire to m_axis_tvalid when unstalled.
- Throughput: 1 beat/cycle sustained with m_axis_tready=1.
- Capacity: 2*N_STAGES beats. After m_axis_tready deasserts, s_axis keeps accepting until all stages are full.
- AXI rules:
  - Once m_axis_tvalid=1, it and the payload hold stable until accepted.
  - s_axis_tready never depends combinationally on m_axis_tready.
- Ordering: strict in-order delivery; no beat is dropped or duplicated; tkeep/tlast travel with their tdata.
- Simultaneous fill and drain in the same cycle is a legal pass-through case and must not stall.

Optional Feature:
- Macro: AXIS_REG_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (32 bits).
  - Counts cycles with m_axis_tvalid=1 & m_axis_tready=0.
  - Saturates at 2^32-1 and clears on aresetn=0.
- Undefined: the port and counter are absent. Datapath behaviour is identical either way.

Test Plan:
- Reset release, N_STAGES=2, source streams 0x1..0x8 with tlast on 0x8, sink ready=1:
  - s_axis_tready=1 one cycle after aresetn rises.
  - First m_axis beat 0x1 appears 2 cycles after its fire.
  - 8 beats are delivered on 8 consecutive cycles, with tlast only on 0x8.
- Sink ready held 0, source always valid:
  - Exactly 4 beats (2*N_STAGES) are accepted, then s_axis_tready=0.
  - m_axis_tdata holds 0x1 stable.
  - With the macro defined, stall_cnt increments by 1 per cycle.
- Sink ready toggles 1,0,1,0 with source continuous, values 0..63 with random tkeep:
  - Output is 0..63 in order with matching tkeep; no loss or duplication.
- Source valid random 50%, sink ready random 50%, 10k beats, N_STAGES=1 and N_STAGES=4:
  - Scoreboard matches.
  - The assertion "m_axis_tvalid & ~m_axis_tready implies payload stable next cycle" never fires.
- aresetn pulsed low for 3 cycles mid-packet with 3 beats buffered:
  - m_axis_tvalid drops asynchronously.
  - After release, only new beats appear; stall_cnt=0.
